// File: rtl/clock_divider.sv
// -----------------------------------------------------------------------------
// clock_divider
//
// Divides clk_in by a runtime-selectable integer ratio N (1 .. 2^WIDTH-1)
// with 50 % duty. Odd ratios reach 50 % duty because the high phase is
// trimmed by half an input cycle. A retiming flop on the falling edge does
// the trimming.
//
// The requested ratio is latched into div_q only at a period boundary, so a
// change on div never disturbs the period that is already running.
//
// Output modes, selected by the latched ratio div_q:
//   0     : clk_out held low
//   1     : clk_out = clk_in, gated by a registered enable
//   even  : clk_out = clk_p (rising-edge register)
//   odd   : clk_out = clk_p & clk_n (clk_n is clk_p delayed half a cycle)
//
// Parameters
//   WIDTH   : width of the divide-ratio input and of the internal counter
//
// Ports
//   clk_in  : input clock; both edges are used
//   rst     : synchronous active-high reset
//   div     : requested divide ratio N, unsigned
//   clk_out : divided clock
// -----------------------------------------------------------------------------

`timescale 1ns / 1ps

module clock_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [WIDTH-1:0] div,
    output logic             clk_out
);

    typedef enum logic [1:0] {
        ModeOff,
        ModeBypass,
        ModeEven,
        ModeOdd
    } mode_e;

    // Latched ratio and divider state.
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             clk_p_q, clk_p_d;
    logic             clk_n_q;
    logic             bypass_en_q, bypass_en_d;

    // Decode of the latched ratio.
    logic [WIDTH:0]   half;      // ceil(div_q / 2), one bit wider so 2^WIDTH-1 cannot wrap
    logic [WIDTH-1:0] last;      // div_q - 1, the terminal count
    logic             counting;  // div_q >= 2
    logic             terminal;
    logic             load;
    mode_e            mode;

    always_comb begin
        half     = ({1'b0, div_q} + (WIDTH + 1)'(1)) >> 1;
        last     = div_q - WIDTH'(1);
        counting = (div_q > WIDTH'(1));
        terminal = counting && (cnt_q == last);
        // Ratios 0 and 1 have no period to finish, so they reload every edge.
        load     = !counting || terminal;
    end

    always_comb begin
        if (div_q == '0) begin
            mode = ModeOff;
        end else if (div_q == WIDTH'(1)) begin
            mode = ModeBypass;
        end else if (div_q[0]) begin
            mode = ModeOdd;
        end else begin
            mode = ModeEven;
        end
    end

    // Next-state logic for the rising-edge registers.
    always_comb begin
        div_d       = div_q;
        cnt_d       = '0;
        clk_p_d     = 1'b0;
        bypass_en_d = 1'b0;

        if (load) begin
            div_d = div;
        end

        if (counting && !terminal) begin
            cnt_d = cnt_q + WIDTH'(1);
        end

        // Compare against the pre-increment count: the first edge of every
        // period (cnt == 0) raises clk_p, and it stays high for `half` edges.
        clk_p_d = ({1'b0, cnt_q} < half);

        bypass_en_d = (div_q == WIDTH'(1));
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            // The ratio keeps tracking div during reset, so the first
            // un-reset edge already counts with the requested ratio.
            div_q       <= div;
            cnt_q       <= '0;
            clk_p_q     <= 1'b0;
            bypass_en_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            clk_p_q     <= clk_p_d;
            bypass_en_q <= bypass_en_d;
        end
    end

    // Half-cycle-delayed copy of clk_p. ANDed with clk_p, it delays the rising
    // edge by half an input cycle. The falling edge is left alone, which gives
    // odd ratios an exact N/2 high time.
    always_ff @(negedge clk_in) begin
        if (rst) begin
            clk_n_q <= 1'b0;
        end else begin
            clk_n_q <= clk_p_q;
        end
    end

    // Output select. Only the bypass mode lets clk_in through combinationally.
    // That path is gated by a register that changes while clk_in is high, so
    // it cannot open or close in the middle of a low phase.
    always_comb begin
        clk_out = 1'b0;
        unique case (mode)
            ModeOff:    clk_out = 1'b0;
            ModeBypass: clk_out = clk_in & bypass_en_q;
            ModeEven:   clk_out = clk_p_q;
            ModeOdd:    clk_out = clk_p_q & clk_n_q;
            default:    clk_out = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_clock_divider.sv
`timescale 1ns / 1ps

module tb_clock_divider;

    localparam int unsigned WIDTH = 8;

    logic             clk_in;
    logic             rst;
    logic [WIDTH-1:0] div;
    logic             clk_out;

    int n_cmp = 0;
    int n_err = 0;

    longint rise_q[$];
    longint fall_q[$];

    clock_divider #(
        .WIDTH(WIDTH)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .div    (div),
        .clk_out(clk_out)
    );

    // 10 ns clock: rising edges at 5, 15, 25 ..., falling edges at 10, 20 ...
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Timestamps of every clk_out edge, cleared at the start of each step.
    always @(posedge clk_out) rise_q.push_back(longint'($time));
    always @(negedge clk_out) fall_q.push_back(longint'($time));

    function automatic longint rise_at(input int i);
        if (i < rise_q.size()) return rise_q[i];
        return -1;
    endfunction

    function automatic longint fall_at(input int i);
        if (i < fall_q.size()) return fall_q[i];
        return -1;
    endfunction

    task automatic clear_edges();
        rise_q.delete();
        fall_q.delete();
    endtask

    task automatic wait_to(input longint t);
        if (t > longint'($time)) #(t - longint'($time));
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // ---- div = 7: reset for 20 ns, then run ~1000 ns ----
        rst = 1'b1;
        div = 8'd7;
        wait_to(12);
        check("reset_low", longint'(clk_out), 0);
        wait_to(20);
        rst = 1'b0;
        clear_edges();
        // First un-reset rising edge at 25: clk_p rises, clk_out waits for 30.
        wait_to(27);
        check("odd_half_delay", longint'(clk_out), 0);
        wait_to(32);
        check("odd_first_high", longint'(clk_out), 1);
        wait_to(1022);
        check("div7_rise0", rise_at(0), 30);
        check("div7_fall0", fall_at(0), 65);
        check("div7_period", rise_at(1) - rise_at(0), 70);
        check("div7_high", fall_at(1) - rise_at(1), 35);
        check("div7_low", rise_at(2) - fall_at(1), 35);
        check("div7_rises", longint'(rise_q.size()), 15);

        // ---- div 7 -> 4 mid-period (period began at 1005) ----
        div = 8'd4;
        clear_edges();
        wait_to(1202);
        check("chg_fall_intact", fall_at(0), 1045);
        check("chg_first4_rise", rise_at(0), 1075);
        check("chg_fall1", fall_at(1), 1095);
        check("chg_period4", rise_at(1) - rise_at(0), 40);
        check("chg_rise2", rise_at(2), 1155);
        check("chg_high_now", longint'(clk_out), 1);

        // ---- reset mid-high, then div = 4 restart ----
        rst = 1'b1;
        wait_to(1207);
        check("rst_abort_low", longint'(clk_out), 0);
        wait_to(1212);
        rst = 1'b0;
        clear_edges();
        wait_to(1302);
        check("div4_rise0", rise_at(0), 1215);
        check("div4_high", fall_at(0) - rise_at(0), 20);
        check("div4_period", rise_at(1) - rise_at(0), 40);

        // ---- div = 6, one-cycle reset pulse in a high phase ----
        div = 8'd6;
        clear_edges();
        wait_to(1402);
        check("div6_high_now", longint'(clk_out), 1);
        rst = 1'b1;
        wait_to(1407);
        check("div6_rst_low", longint'(clk_out), 0);
        wait_to(1412);
        rst = 1'b0;
        wait_to(1482);
        check("div6_tail4_fall", fall_at(0), 1315);
        check("div6_rise0", rise_at(0), 1335);
        check("div6_fall1", fall_at(1), 1365);
        check("div6_rise1", rise_at(1), 1395);
        check("div6_abort_fall", fall_at(2), 1405);
        check("div6_restart", rise_at(2), 1415);
        check("div6_restart_hi", fall_at(3) - rise_at(2), 30);
        check("div6_next_rise", rise_at(3), 1475);

        // ---- div = 1: bypass (loads at terminal edge 1525) ----
        div = 8'd1;
        wait_to(1527);
        check("byp_gated_off", longint'(clk_out), 0);
        wait_to(1537);
        check("byp_hi0", longint'(clk_out), 1);
        wait_to(1542);
        check("byp_lo0", longint'(clk_out), 0);
        wait_to(1547);
        check("byp_hi1", longint'(clk_out), 1);
        wait_to(1550);
        clear_edges();
        wait_to(1650);
        check("byp_rises", longint'(rise_q.size()), 10);

        // ---- rst with div = 1, then div = 0 ----
        wait_to(1652);
        rst = 1'b1;
        wait_to(1657);
        check("byp_rst_low", longint'(clk_out), 0);
        wait_to(1662);
        div = 8'd0;
        wait_to(1672);
        rst = 1'b0;
        clear_edges();
        wait_to(1677);
        check("div0_low_a", longint'(clk_out), 0);
        wait_to(1682);
        check("div0_low_b", longint'(clk_out), 0);
        wait_to(1772);
        check("div0_no_rise", longint'(rise_q.size()), 0);

        // ---- div = 255 ----
        rst = 1'b1;
        div = 8'd255;
        wait_to(1782);
        rst = 1'b0;
        clear_edges();
        wait_to(1787);
        check("div255_delay", longint'(clk_out), 0);
        wait_to(4402);
        check("div255_rise0", rise_at(0), 1790);
        check("div255_high", fall_at(0) - rise_at(0), 1275);
        check("div255_period", rise_at(1) - rise_at(0), 2550);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
